spi_slave_cmd_ctrl: RTL and testbench
=====================================

// Module: spi_slave_cmd_ctrl
// PURPOSE
// Transaction controller for the SPI slave byte engine, in the sysClk domain.
// Turns the stream of received bytes within one /SS frame into command/address/data
// phases. Drives a simple register bus: burst read/write with address auto-increment.
// Supplies the next byte the slave must shift out on MISO.
// PARAMETERS
// ADDR_W     8     register bus address width; address wraps modulo 2**ADDR_W
// DATA_W     8     register data width; fixed to 8 (one SPI byte per register)
// ID_BYTE    8'hA5 byte returned in the first data phase of CMD_ID
// PORTS
// sysClk_i      in   1       system clock
// reset_i       in   1       asynchronous reset, active-high
// ss_active_i   in   1       synced frame-active (/SS low), from slave
// rx_valid_i    in   1       one-cycle pulse: byte_rx_i holds a completed byte
// byte_rx_i     in   8       received byte
// byte_tx_o     out  8       byte to shift out in the next byte slot
// reg_addr_o    out  ADDR_W  register bus address
// reg_wdata_o   out  8       register write data
// reg_we_o      out  1       one-cycle write strobe
// reg_re_o      out  1       one-cycle read strobe; reg_rdata_i valid the following cycle
// reg_rdata_i   in   8       register read data
// frame_done_o  out  1       one-cycle pulse at end of a frame whose command was valid
// err_o         out  1       sticky: unknown command seen; cleared by CMD_STATUS read
// BEHAVIOUR
// - Reset: state IDLE; byte_tx_o=8'h00; reg_addr_o=0; reg_wdata_o=0; all strobes 0;
//   frame_done_o=0; err_o=0.
// - Commands (byte 0 of the frame): CMD_WRITE=8'h02, CMD_READ=8'h03,
//   CMD_STATUS=8'h05, CMD_ID=8'h9F. Byte 1 is the address for WRITE/READ only.
// - States: IDLE, CMD, ADDR, WDATA, RFETCH, RDATA, STAT, IGNORE.
//   IDLE->CMD on ss_active_i=1; byte_tx_o=8'h00 during the command slot.
//   CMD on rx_valid_i: WRITE/READ->ADDR; STATUS->STAT; ID->STAT with byte_tx_o=ID_BYTE;
//   any other value->IGNORE, and err_o<=1.
//   STATUS loads byte_tx_o={err_o,7'd0} in the same cycle and clears err_o.
//   ADDR on rx_valid_i: reg_addr_o<=byte. WRITE->WDATA. READ->RFETCH with reg_re_o=1
//   on the next cycle.
//   RFETCH (1 cycle): byte_tx_o<=reg_rdata_i; ->RDATA. rx_valid_i to next byte_tx_o
//   update is 3 cycles max.
//   WDATA on rx_valid_i: reg_wdata_o<=byte, reg_we_o=1 next cycle with the current addr.
//   The address increments the cycle after the strobe.
//   RDATA on rx_valid_i: the byte is don't-care. Address increments, reg_re_o pulses,
//   then RFETCH reloads byte_tx_o.
//   STAT, IGNORE: rx_valid_i is consumed with no bus activity; byte_tx_o is held.
// - Frame end: ss_active_i=0 in any state other than IDLE -> IDLE next cycle.
//   byte_tx_o<=8'h00. frame_done_o pulses if the command was valid.
//   frame_done_o does not pulse from IDLE, CMD or IGNORE.
// - rx_valid_i with ss_active_i falling in the same cycle: the byte is fully processed
//   first, including any pending strobe. Then IDLE.
// - A strobe is never issued after frame end, except that pending one.
// - Address wrap: 2**ADDR_W-1 increments to 0, with no error.
// - reg_we_o and reg_re_o are never high in the same cycle.
// - rx_valid_i while a strobe is pending is impossible by protocol (bytes >=8 sclk apart).
//   No queueing.
// - Reset mid-frame: immediate return to the reset values. The frame in progress is
//   ignored until ss_active_i is seen low and then high again.
// STRUCTURE
// - Package spi_ctrl_pkg: CtrlState enum; CMD_* localparams; STATUS field positions.
// - Single module, no sub-module: FSM + address counter + tx byte register.
// TESTING
// - WRITE burst 02,10,AA,BB,CC: we at addr 10/11/12 with data AA/BB/CC; one
//   frame_done_o pulse.
// - READ 03,FE + 3 dummy: re at FE,FF,00 (wrap). byte_tx_o = regs[FE],[FF],[00]
//   before each slot.
// - Unknown cmd 7E then 3 bytes: no strobes, err_o=1. Next frame STATUS: byte_tx_o=80,
//   err_o->0.
// - ID frame 9F,00: byte_tx_o=A5 in the second slot; frame_done_o pulses.
// - ss_active_i drops in the same cycle as the 2nd WRITE data byte: that write occurs,
//   no further strobes, IDLE.
// - reset_i mid-READ burst: outputs go to reset values asynchronously. No strobes until
//   a new frame starts.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// SPI slave command controller: shared types and constants.
// FSM state enum, command opcodes, status byte field positions.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RFETCH,
    ST_RDATA,
    ST_STAT,
    ST_IGNORE
  } CtrlState;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;
  localparam logic [7:0] CMD_ID     = 8'h9F;

  localparam int STAT_ERR_BIT = 7;

  // States reached only after a valid command byte
  function automatic logic cmd_ok_state(CtrlState s);
    return s inside {ST_ADDR, ST_WDATA, ST_RFETCH,
                     ST_RDATA, ST_STAT};
  endfunction

endpackage

// File: rtl/spi_slave_cmd_ctrl.sv
// SPI slave transaction controller (sysClk domain).
// Splits each /SS frame into command/address/data phases and drives a
// register bus with burst read/write and address auto-increment.
// Ports:
//   sysClk_i, reset_i          clock, async active-high reset
//   ss_active_i                frame active (synced /SS low)
//   rx_valid_i, byte_rx_i      received byte strobe and value
//   byte_tx_o                  next byte to shift out on MISO
//   reg_addr_o, reg_wdata_o    register bus address / write data
//   reg_we_o, reg_re_o         one-cycle write / read strobes
//   reg_rdata_i                read data, valid the cycle after reg_re_o
//   frame_done_o               pulse at end of a valid-command frame
//   err_o                      sticky unknown-command flag
module spi_slave_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8,
  parameter logic [7:0]  ID_BYTE = 8'hA5
) (
  input  logic              sysClk_i,
  input  logic              reset_i,
  input  logic              ss_active_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        byte_rx_i,
  output logic [7:0]        byte_tx_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              frame_done_o,
  output logic              err_o
);

  CtrlState          state_q, state_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  // Set once /SS has been seen inactive; blocks
  // joining a frame already running at reset.
  logic              arm_q, arm_d;
  logic              pend;

  assign pend = we_q | re_q;

  always_ff @(posedge sysClk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      tx_q    <= 8'h00;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      arm_q   <= arm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    rd_d    = rd_q;
    arm_d   = arm_q | ~ss_active_i;

    // Post-write increment, cycle after the strobe
    if (we_q) addr_d = addr_q + ADDR_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (ss_active_i && arm_q) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (rx_valid_i) begin
          unique case (1'b1)
            (byte_rx_i == CMD_WRITE): begin
              rd_d    = 1'b0;
              state_d = ST_ADDR;
            end
            (byte_rx_i == CMD_READ): begin
              rd_d    = 1'b1;
              state_d = ST_ADDR;
            end
            (byte_rx_i == CMD_STATUS): begin
              tx_d               = 8'h00;
              tx_d[STAT_ERR_BIT] = err_q;
              err_d              = 1'b0;
              state_d            = ST_STAT;
            end
            (byte_rx_i == CMD_ID): begin
              tx_d    = ID_BYTE;
              state_d = ST_STAT;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_IGNORE;
            end
          endcase
        end
      end
      ST_ADDR: begin
        // Read strobe is out this cycle; capture next
        if (re_q) begin
          state_d = ST_RFETCH;
        end else if (rx_valid_i) begin
          addr_d = ADDR_W'(byte_rx_i);
          if (rd_q) re_d = 1'b1;
          else      state_d = ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (rx_valid_i) begin
          wdata_d = byte_rx_i;
          we_d    = 1'b1;
        end
      end
      ST_RFETCH: begin
        tx_d    = reg_rdata_i;
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (re_q) begin
          state_d = ST_RFETCH;
        end else if (rx_valid_i) begin
          addr_d = addr_q + ADDR_W'(1);
          re_d   = 1'b1;
        end
      end
      ST_STAT, ST_IGNORE: begin
      end
    endcase

    // Frame end waits for a byte in flight and
    // its strobe to finish before returning idle.
    if (state_q != ST_IDLE && !ss_active_i &&
        !rx_valid_i && !pend) begin
      state_d = ST_IDLE;
      tx_d    = 8'h00;
      done_d  = cmd_ok_state(state_q);
    end
  end

  assign byte_tx_o    = tx_q;
  assign reg_addr_o   = addr_q;
  assign reg_wdata_o  = wdata_q;
  assign reg_we_o     = we_q;
  assign reg_re_o     = re_q;
  assign frame_done_o = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Directed bench for spi_slave_cmd_ctrl.
// Frame table plus reset-mid-frame sequence.
module tb_spi_slave_cmd_ctrl;

  localparam int GAP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic       rx_v;
  logic [7:0] rx_b;
  logic [7:0] tx;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we, re;
  logic [7:0] rdata;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] we_a[$];
  logic [7:0] we_dq[$];
  logic [7:0] re_a[$];
  int         done_cnt;

  always #5 clk = ~clk;

  spi_slave_cmd_ctrl dut (
    .sysClk_i    (clk),
    .reset_i     (rst),
    .ss_active_i (ss),
    .rx_valid_i  (rx_v),
    .byte_rx_i   (rx_b),
    .byte_tx_o   (tx),
    .reg_addr_o  (addr),
    .reg_wdata_o (wdata),
    .reg_we_o    (we),
    .reg_re_o    (re),
    .reg_rdata_i (rdata),
    .frame_done_o(done),
    .err_o       (err)
  );

  // Register file model: regs[a] = a ^ 5C
  always @(posedge clk)
    rdata <= re ? (addr ^ 8'h5C) : 8'hEE;

  always @(negedge clk) begin
    if (we) begin
      we_a.push_back(addr);
      we_dq.push_back(wdata);
    end
    if (re) re_a.push_back(addr);
    if (done) done_cnt++;
    if (we && re) begin
      n_cmp++;
      n_err++;
      $display("FAIL we_re_overlap act=11 exp=not both");
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [0:4][7:0] by;
    logic [3:0]      nb;
    logic [3:0]      drop;
    logic [0:4][7:0] tx;
    logic [2:0]      nwe;
    logic [0:2][7:0] wa;
    logic [0:2][7:0] wd;
    logic [2:0]      nre;
    logic [0:3][7:0] ra;
    logic            done;
    logic            err;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic clr_logs();
    we_a.delete();
    we_dq.delete();
    re_a.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b,
                      input logic drop);
    rx_v = 1'b1;
    rx_b = b;
    if (drop) ss = 1'b0;
    @(negedge clk);
    rx_v = 1'b0;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    v = vecs[vi];
    clr_logs();
    ss = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < int'(v.nb); i++) begin
      repeat (GAP) @(negedge clk);
      chk($sformatf("v%0d_tx%0d", vi, i), 32'(tx), 32'(v.tx[i]));
      send(v.by[i], (i == int'(v.drop)));
    end
    repeat (GAP) @(negedge clk);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    chk($sformatf("v%0d_nwe", vi), we_a.size(), 32'(v.nwe));
    for (int j = 0; j < int'(v.nwe); j++) begin
      if (j < we_a.size()) begin
        chk($sformatf("v%0d_wa%0d", vi, j), 32'(we_a[j]), 32'(v.wa[j]));
        chk($sformatf("v%0d_wd%0d", vi, j), 32'(we_dq[j]), 32'(v.wd[j]));
      end
    end
    chk($sformatf("v%0d_nre", vi), re_a.size(), 32'(v.nre));
    for (int j = 0; j < int'(v.nre); j++) begin
      if (j < re_a.size())
        chk($sformatf("v%0d_ra%0d", vi, j), 32'(re_a[j]), 32'(v.ra[j]));
    end
    chk($sformatf("v%0d_done", vi), done_cnt, v.done ? 1 : 0);
    chk($sformatf("v%0d_err", vi), 32'(err), 32'(v.err));
    chk($sformatf("v%0d_tx_idle", vi), 32'(tx), 32'h00);
  endtask

  initial begin
    vecs[0] = '{by:{8'h02,8'h10,8'hAA,8'hBB,8'hCC}, nb:5, drop:15,
                tx:40'h0, nwe:3, wa:{8'h10,8'h11,8'h12},
                wd:{8'hAA,8'hBB,8'hCC}, nre:0, ra:32'h0,
                done:1, err:0};
    vecs[1] = '{by:{8'h03,8'hFE,8'h00,8'h00,8'h00}, nb:5, drop:15,
                tx:{8'h00,8'h00,8'hA2,8'hA3,8'h5C}, nwe:0, wa:24'h0,
                wd:24'h0, nre:4, ra:{8'hFE,8'hFF,8'h00,8'h01},
                done:1, err:0};
    vecs[2] = '{by:{8'h7E,8'h11,8'h22,8'h33,8'h00}, nb:4, drop:15,
                tx:40'h0, nwe:0, wa:24'h0, wd:24'h0, nre:0, ra:32'h0,
                done:0, err:1};
    vecs[3] = '{by:{8'h05,8'h00,8'h00,8'h00,8'h00}, nb:2, drop:15,
                tx:{8'h00,8'h80,8'h00,8'h00,8'h00}, nwe:0, wa:24'h0,
                wd:24'h0, nre:0, ra:32'h0, done:1, err:0};
    vecs[4] = '{by:{8'h05,8'h00,8'h00,8'h00,8'h00}, nb:2, drop:15,
                tx:40'h0, nwe:0, wa:24'h0, wd:24'h0, nre:0, ra:32'h0,
                done:1, err:0};
    vecs[5] = '{by:{8'h9F,8'h00,8'h00,8'h00,8'h00}, nb:2, drop:15,
                tx:{8'h00,8'hA5,8'h00,8'h00,8'h00}, nwe:0, wa:24'h0,
                wd:24'h0, nre:0, ra:32'h0, done:1, err:0};
    vecs[6] = '{by:{8'h02,8'h40,8'h11,8'h22,8'h00}, nb:4, drop:3,
                tx:40'h0, nwe:2, wa:{8'h40,8'h41,8'h00},
                wd:{8'h11,8'h22,8'h00}, nre:0, ra:32'h0,
                done:1, err:0};
    vecs[7] = '{by:40'h0, nb:0, drop:15, tx:40'h0, nwe:0, wa:24'h0,
                wd:24'h0, nre:0, ra:32'h0, done:0, err:0};
    vecs[8] = '{by:{8'h03,8'h80,8'h00,8'h00,8'h00}, nb:3, drop:2,
                tx:{8'h00,8'h00,8'hDC,8'h00,8'h00}, nwe:0, wa:24'h0,
                wd:24'h0, nre:2, ra:{8'h80,8'h81,8'h00,8'h00},
                done:1, err:0};

    rst  = 1'b1;
    ss   = 1'b0;
    rx_v = 1'b0;
    rx_b = 8'h00;
    done_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(tx),    32'h00);
    chk("rst_addr",  32'(addr),  32'h00);
    chk("rst_wdata", 32'(wdata), 32'h00);
    chk("rst_we",    32'(we),    32'h0);
    chk("rst_re",    32'(re),    32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_err",   32'(err),   32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < NV; k++) run_vec(k);

    // Reset in the middle of a READ burst
    run_vec(2);
    clr_logs();
    ss = 1'b1;
    repeat (3) @(negedge clk);
    repeat (GAP) @(negedge clk);
    send(8'h03, 1'b0);
    repeat (GAP) @(negedge clk);
    send(8'h30, 1'b0);
    repeat (GAP) @(negedge clk);
    chk("mid_tx_pre", 32'(tx), 32'h6C);
    chk("mid_err_pre", 32'(err), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_tx",   32'(tx),   32'h00);
    chk("arst_addr", 32'(addr), 32'h00);
    chk("arst_err",  32'(err),  32'h0);
    chk("arst_re",   32'(re),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    clr_logs();
    for (int i = 0; i < 3; i++) begin
      repeat (GAP) @(negedge clk);
      send(8'h9F, 1'b0);
    end
    repeat (GAP) @(negedge clk);
    chk("post_rst_we", we_a.size(), 0);
    chk("post_rst_re", re_a.size(), 0);
    chk("post_rst_tx", 32'(tx), 32'h00);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_done", done_cnt, 0);
    run_vec(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
